// File: rtl/taillamp_input_cond.sv
// Input conditioning for the tail-lamp sequencer: synchronises and debounces the
// hazard/left/right switches, qualifies left/right, and paces the sequence with TICK.
module taillamp_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned TICK_DIV        = 12500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_HAZ,
    input  logic SW_LEFT,
    input  logic SW_RIGHT,
    output logic HAZ,
    output logic LEFT,
    output logic RIGHT,
    output logic HAZ_EDGE,
    output logic CONFLICT,
    output logic TICK
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(TICK_DIV - 1);

    // Bit order everywhere: [0] hazard, [1] left, [2] right.
    logic [2:0]         raw;
    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         st_q, st_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;

    logic haz_q, left_q, right_q, edge_q, conf_q, tick_q;
    logic haz_d, left_d, right_d, edge_d, conf_d, tick_d;
    logic [PW-1:0] pc_q, pc_d;
    logic restart;

    assign raw = {SW_RIGHT, SW_LEFT, SW_HAZ};

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] == st_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                st_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        haz_d   = st_q[0];
        left_d  = st_q[1] & ~st_q[2];
        right_d = st_q[2] & ~st_q[1];
        conf_d  = st_q[1] & st_q[2];
        edge_d  = st_q[0] & ~haz_q;
    end

    // A change in the qualified request restarts the period so the first step is a full period away.
    assign restart = {haz_d, left_d, right_d} != {haz_q, left_q, right_q};

    always_comb begin
        pc_d   = pc_q + 1'b1;
        tick_d = 1'b0;
        if (restart) begin
            pc_d = '0;
        end else if (pc_q == PC_LAST) begin
            pc_d   = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            st_q    <= '0;
            cnt_q   <= '0;
            haz_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            edge_q  <= 1'b0;
            conf_q  <= 1'b0;
            tick_q  <= 1'b0;
            pc_q    <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            haz_q   <= haz_d;
            left_q  <= left_d;
            right_q <= right_d;
            edge_q  <= edge_d;
            conf_q  <= conf_d;
            tick_q  <= tick_d;
            pc_q    <= pc_d;
        end
    end

    assign HAZ      = haz_q;
    assign LEFT     = left_q;
    assign RIGHT    = right_q;
    assign HAZ_EDGE = edge_q;
    assign CONFLICT = conf_q;
    assign TICK     = tick_q;

endmodule

// File: tb/tb_taillamp_input_cond.sv
// Directed bench for taillamp_input_cond: sample-history reference model checked every cycle,
// plus hand-computed expectations at the key timing points.
module tb_taillamp_input_cond;
    localparam int D = 4;
    localparam int T = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SW_HAZ = 1'b1, SW_LEFT = 1'b1, SW_RIGHT = 1'b1;
    logic HAZ, LEFT, RIGHT, HAZ_EDGE, CONFLICT, TICK;

    int n_vec = 0;
    int n_err = 0;

    taillamp_input_cond #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
        .CLK(CLK), .RST(RST), .SW_HAZ(SW_HAZ), .SW_LEFT(SW_LEFT), .SW_RIGHT(SW_RIGHT),
        .HAZ(HAZ), .LEFT(LEFT), .RIGHT(RIGHT), .HAZ_EDGE(HAZ_EDGE),
        .CONFLICT(CONFLICT), .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: a switch's stable level flips once the last D synchronised
    // samples all disagree with it; outputs reflect the stable levels one edge later.
    bit hist[3][$];
    bit mst[3];
    bit eh, el, er, ee, ec, et;
    int since;
    bit mvalid = 0;

    function automatic bit samp(int i, int age);
        if (hist[i].size() > age) return hist[i][hist[i].size() - 1 - age];
        return 1'b0;
    endfunction

    always begin
        bit nh, nl, nr, chg, flip;
        bit raws[3];
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                hist[i].delete();
                mst[i] = 1'b0;
            end
            {eh, el, er, ee, ec, et} = '0;
            since  = 0;
            mvalid = 1;
        end else begin
            nh  = mst[0];
            nl  = mst[1] & ~mst[2];
            nr  = mst[2] & ~mst[1];
            chg = ({nh, nl, nr} != {eh, el, er});
            since = chg ? 0 : since + 1;
            et = !chg && (since % T == 0);
            ee = nh & ~eh;
            ec = mst[1] & mst[2];
            eh = nh; el = nl; er = nr;
            raws[0] = SW_HAZ; raws[1] = SW_LEFT; raws[2] = SW_RIGHT;
            for (int i = 0; i < 3; i++) begin
                hist[i].push_back(raws[i]);
                if (hist[i].size() > D + 2) void'(hist[i].pop_front());
                flip = 1'b1;
                for (int a = 2; a <= D + 1; a++)
                    if (samp(i, a) == mst[i]) flip = 1'b0;
                if (flip) mst[i] = ~mst[i];
            end
        end
        #1;
        if (mvalid) begin
            check("m_HAZ", HAZ, eh);
            check("m_LEFT", LEFT, el);
            check("m_RIGHT", RIGHT, er);
            check("m_HAZ_EDGE", HAZ_EDGE, ee);
            check("m_CONFLICT", CONFLICT, ec);
            check("m_TICK", TICK, et);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int cnt;
        bit seen;

        // 1: reset with all switches high
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("rst_zero", |{HAZ, LEFT, RIGHT, HAZ_EDGE, CONFLICT, TICK}, 1'b0);
        end
        RST = 1'b0;
        step(6);
        check("rst_haz_early", HAZ, 1'b0);
        step(1);
        check("rst_haz_rise", HAZ, 1'b1);
        check("rst_conf_rise", CONFLICT, 1'b1);
        check("rst_edge", HAZ_EDGE, 1'b1);
        check("rst_left", LEFT, 1'b0);
        check("rst_right", RIGHT, 1'b0);
        {SW_HAZ, SW_LEFT, SW_RIGHT} = 3'b000;
        step(6);
        check("rel_conf_hold", CONFLICT, 1'b1);
        step(1);
        check("rel_conf_drop", CONFLICT, 1'b0);
        check("rel_no_left", LEFT, 1'b0);
        check("rel_no_right", RIGHT, 1'b0);
        step(4);

        // 2: bounce rejection then valid press
        seen = 0;
        SW_LEFT = 1'b1; step(1); seen |= LEFT; step(1); seen |= LEFT; step(1); seen |= LEFT;
        SW_LEFT = 1'b0; step(1); seen |= LEFT; step(1); seen |= LEFT;
        SW_LEFT = 1'b1; step(1); seen |= LEFT; step(1); seen |= LEFT; step(1); seen |= LEFT;
        SW_LEFT = 1'b0;
        for (int k = 0; k < 12; k++) begin step(1); seen |= LEFT; end
        check("bounce_reject", seen, 1'b0);
        SW_LEFT = 1'b1;
        step(6);
        check("left_early", LEFT, 1'b0);
        step(1);
        check("left_rise", LEFT, 1'b1);
        step(3);

        // 3: conflict and resolution
        SW_RIGHT = 1'b1;
        step(6);
        check("cf_left_hold", LEFT, 1'b1);
        step(1);
        check("cf_left_drop", LEFT, 1'b0);
        check("cf_conf_rise", CONFLICT, 1'b1);
        check("cf_right_off", RIGHT, 1'b0);
        SW_LEFT = 1'b0;
        step(6);
        check("cf_conf_hold", CONFLICT, 1'b1);
        step(1);
        check("cf_conf_drop", CONFLICT, 1'b0);
        check("cf_right_rise", RIGHT, 1'b1);

        // 5: tick spacing while RIGHT steady
        for (int k = 1; k <= 43; k++) begin
            step(1);
            check("tick_steady", TICK, (k % T == 0));
        end
        {SW_LEFT, SW_RIGHT} = 2'b10;
        step(7);
        check("tog_left", LEFT, 1'b1);
        check("tog_right", RIGHT, 1'b0);
        check("tog_noconf", CONFLICT, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(1);
            check("tog_no_tick", TICK, 1'b0);
        end
        step(1);
        check("tog_tick", TICK, 1'b1);
        SW_LEFT = 1'b0;
        step(12);

        // 4: hazard edge
        SW_HAZ = 1'b1;
        step(6);
        check("he_early", HAZ_EDGE, 1'b0);
        step(1);
        check("he_haz", HAZ, 1'b1);
        check("he_pulse", HAZ_EDGE, 1'b1);
        cnt = 0;
        for (int k = 0; k < 13; k++) begin step(1); cnt += HAZ_EDGE; end
        check("he_no_repeat", (cnt == 0), 1'b1);
        SW_HAZ = 1'b0;
        step(10);
        check("he_released", HAZ, 1'b0);
        SW_HAZ = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin step(1); cnt += HAZ_EDGE; end
        check("he_one_more", (cnt == 1), 1'b1);
        SW_HAZ = 1'b0;
        step(10);

        // 6: reset mid-debounce
        SW_HAZ = 1'b1;
        step(4);
        RST = 1'b1;
        step(1);
        check("mid_rst_haz", HAZ, 1'b0);
        RST = 1'b0;
        step(6);
        check("mid_haz_early", HAZ, 1'b0);
        step(1);
        check("mid_haz_rise", HAZ, 1'b1);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: run time exceeded, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end
endmodule

// File: doc/taillamp_input_cond.md
# taillamp_input_cond

Input conditioning stage that sits directly upstream of the tail-lamp sequencer. It synchronises and debounces the three raw dashboard switches (hazard, left, right) and resolves an illegal left+right request. It drives clean `HAZ`/`LEFT`/`RIGHT` levels plus a hazard rising-edge pulse. It also produces `TICK`, a one-cycle step enable that paces the lamp sequence at a visible rate.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles required to accept a switch change; legal range ≥ 1.
- `TICK_DIV`, default 12500000: `CLK` cycles per `TICK` pulse; legal range ≥ 2.

Ports:
- `CLK`  in  1  — single clock; all logic on its rising edge.
- `RST`  in  1  — reset, synchronous, active-high.
- `SW_HAZ`  in  1  — raw hazard switch, asynchronous, bouncy.
- `SW_LEFT`  in  1  — raw left-turn switch, asynchronous, bouncy.
- `SW_RIGHT`  in  1  — raw right-turn switch, asynchronous, bouncy.
- `HAZ`  out  1  — debounced hazard level.
- `LEFT`  out  1  — debounced left request, qualified (see Operation).
- `RIGHT`  out  1  — debounced right request, qualified.
- `HAZ_EDGE`  out  1  — one-cycle pulse on each 0→1 transition of the debounced hazard level.
- `CONFLICT`  out  1  — high while debounced left and right are both high.
- `TICK`  out  1  — one-cycle step enable for the sequencer.

## Operation

Synchroniser:
- Each raw switch passes through a 2-flop synchroniser.

Debouncer (one per switch):
- Registers: stable level `st` and counter `cnt`, width ceil(log2(`DEBOUNCE_CYCLES`+1)).
- If sync == `st`: `cnt` ← 0.
- Otherwise, if `cnt` == `DEBOUNCE_CYCLES`−1: `st` ← sync and `cnt` ← 0.
- Otherwise: `cnt` ← `cnt`+1.
- Any bounce shorter than `DEBOUNCE_CYCLES` cycles is discarded.

Qualification (registered outputs):
- `HAZ` = `st_h`.
- `LEFT` = `st_l` & ~`st_r`.
- `RIGHT` = `st_r` & ~`st_l`.
- `CONFLICT` = `st_l` & `st_r`.
- Left and right are never both asserted; a conflict yields neither.
- `HAZ` is independent of left/right; the downstream sequencer gives it priority.
- `HAZ_EDGE` = `st_h` & ~(registered `HAZ`). It is exactly one cycle wide and aligned with the first cycle `HAZ` is high.

Tick prescaler:
- Counter `pc` runs 0..`TICK_DIV`−1 and wraps to 0.
- `TICK` is high in the cycle after `pc` == `TICK_DIV`−1, giving exactly one pulse per `TICK_DIV` cycles.
- Restart rule: `pc` ← 0, with no `TICK` that cycle, on any cycle where the next value of (`LEFT`, `RIGHT`, `HAZ`) differs from the current value.
- The restart guarantees the first sequencer step after a new request comes a full period later.
- Restart has priority over wrap when both occur in the same cycle.

Reset (`RST` high at a rising edge):
- Synchronisers, `st_*`, `cnt_*` and `pc` are cleared to 0.
- All outputs are 0 on the following cycle.
- Reset mid-debounce discards the partial count.
- After `RST` is released, a switch already held high re-qualifies after the full latency.

## Timing

- Switch-to-output latency, measured from the first `CLK` edge sampling the new raw level (constant thereafter):
  - 2 edges for the synchroniser;
  - `DEBOUNCE_CYCLES` edges for the debouncer;
  - 1 edge for the output register;
  - total `DEBOUNCE_CYCLES`+3.
- Release (1→0) has the same latency as assertion.
- `HAZ_EDGE` asserts in the same cycle `HAZ` first reads 1.
- `TICK` period is `TICK_DIV` cycles, pulse width 1 cycle.
- The first `TICK` after a qualifying output change comes exactly `TICK_DIV` cycles after that change.
- Left and right releasing in the same cycle produces no `CONFLICT` transient.
- One switch releasing during a conflict makes the other direction assert on that same output edge.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `TICK_DIV`=8.

1. **Reset:** hold `RST` 3 cycles with all switches high → all outputs 0 while in reset; release → `HAZ`/`CONFLICT` rise exactly 7 cycles later; `LEFT`/`RIGHT` stay 0.
2. **Bounce rejection:** `SW_LEFT` pulses high 3 cycles, low 2, high 3, then low → `LEFT` never asserts. Then hold `SW_LEFT` high → `LEFT`=1 exactly 7 cycles after the first sampling edge.
3. **Conflict:** `LEFT` established, then `SW_RIGHT` goes high → when right qualifies, `LEFT`→0 and `CONFLICT`→1 together. Drop `SW_LEFT` → 7 cycles later `CONFLICT`→0 and `RIGHT`→1 on the same edge.
4. **Hazard edge:** assert `SW_HAZ` for 20 cycles → `HAZ_EDGE` is one cycle high, coincident with the first `HAZ`=1. No further pulse while held. Re-assertion after release produces exactly one more pulse.
5. **Tick spacing:** `RIGHT` steady for 40 cycles → `TICK` pulses every 8 cycles, the first exactly 8 cycles after `RIGHT` rose. Toggling to `LEFT` mid-period → no `TICK` for the next 7 cycles, then a pulse on the 8th.
6. **Reset mid-debounce:** `SW_HAZ` high, `RST` pulsed one cycle at cycle 3 of debounce → `HAZ` rises 7 cycles after `RST` deasserts, not earlier.
